// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the sequential multiply path.
package mul_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PP0,
    PP1,
    PP2,
    PP3,
    FIX,
    DONE
  } statetype;

  // Alignment of a partial product inside the double-width accumulator.
  typedef enum logic [1:0] {
    SH_NONE,
    SH_HALF,
    SH_FULL
  } shift_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

endpackage

// File: rtl/mul_seq_acc.sv
// Double-width partial-product accumulator with final conditional negate.
module mul_seq_acc
  import mul_seq_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_add_en,
  input  shift_t            i_shift,
  input  logic [XLEN-1:0]   i_pp,
  input  logic              i_fix_en,
  input  logic              i_neg,
  output logic [2*XLEN-1:0] o_fixed
);

  logic [2*XLEN-1:0] r_acc;
  logic [2*XLEN-1:0] w_pp_ext;
  logic [2*XLEN-1:0] w_addend;

  assign w_pp_ext = {{XLEN{1'b0}}, i_pp};

  // Place the partial product at its weight within the accumulator.
  always_comb begin
    w_addend = w_pp_ext;
    case (i_shift)
      SH_HALF: w_addend = w_pp_ext << (XLEN / 2);
      SH_FULL: w_addend = w_pp_ext << XLEN;
      default: w_addend = w_pp_ext;
    endcase
  end

  // Sign-corrected view of the running sum, used by the FIX step.
  assign o_fixed = i_neg ? (~r_acc + 1'b1) : r_acc;

  // Accumulator: clear on accept, add during PP steps, negate in FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_add_en) begin
      r_acc <= r_acc + w_addend;
    end else if (i_fix_en) begin
      r_acc <= o_fixed;
    end
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Four-step sequencer driving an external half-width multiplier to produce
// mul/mulh/mulhsu/mulhu results over a valid/ready handshake.
module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Flush,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic [2:0]        Funct3,
  input  logic [XLEN-1:0]   SrcA,
  input  logic [XLEN-1:0]   SrcB,
  output logic [XLEN/2-1:0] MulA,
  output logic [XLEN/2-1:0] MulB,
  input  logic [XLEN-1:0]   MulP,
  output logic              RespValid,
  input  logic              RespReady,
  output logic [XLEN-1:0]   Result,
  output logic              Busy
);

  localparam int unsigned HALF = XLEN / 2;

  statetype          r_state;
  logic [XLEN-1:0]   r_absa;
  logic [XLEN-1:0]   r_absb;
  logic              r_neg;
  logic [2:0]        r_f3;
  logic [XLEN-1:0]   r_result;

  logic              w_sa;
  logic              w_sb;
  logic [XLEN-1:0]   w_absa;
  logic [XLEN-1:0]   w_absb;
  logic              w_accept;
  logic              w_add_en;
  logic              w_fix_en;
  shift_t            w_shift;
  logic [2*XLEN-1:0] w_fixed;

  assign w_sa   = SrcA[XLEN-1] & ((Funct3 == F3_MULH) | (Funct3 == F3_MULHSU));
  assign w_sb   = SrcB[XLEN-1] & (Funct3 == F3_MULH);
  assign w_absa = w_sa ? (~SrcA + 1'b1) : SrcA;
  assign w_absb = w_sb ? (~SrcB + 1'b1) : SrcB;

  assign w_accept = (r_state == IDLE) & ReqValid & ~Flush;
  assign w_add_en = ((r_state == PP0) | (r_state == PP1) |
                     (r_state == PP2) | (r_state == PP3)) & ~Flush;
  assign w_fix_en = (r_state == FIX) & ~Flush;

  assign ReqReady  = (r_state == IDLE);
  assign Busy      = (r_state != IDLE);
  assign RespValid = (r_state == DONE);
  assign Result    = r_result;

  // Half-operand selection and partial-product weight for each PP step.
  always_comb begin
    MulA    = '0;
    MulB    = '0;
    w_shift = SH_NONE;
    case (r_state)
      PP0: begin
        MulA = r_absa[HALF-1:0];
        MulB = r_absb[HALF-1:0];
      end
      PP1: begin
        MulA    = r_absa[HALF-1:0];
        MulB    = r_absb[XLEN-1:HALF];
        w_shift = SH_HALF;
      end
      PP2: begin
        MulA    = r_absa[XLEN-1:HALF];
        MulB    = r_absb[HALF-1:0];
        w_shift = SH_HALF;
      end
      PP3: begin
        MulA    = r_absa[XLEN-1:HALF];
        MulB    = r_absb[XLEN-1:HALF];
        w_shift = SH_FULL;
      end
      default: ;
    endcase
  end

  mul_seq_acc #(.XLEN(XLEN)) u_acc (
    .clk      (clk),
    .rst_n    (reset),
    .i_clr    (w_accept),
    .i_add_en (w_add_en),
    .i_shift  (w_shift),
    .i_pp     (MulP),
    .i_fix_en (w_fix_en),
    .i_neg    (r_neg),
    .o_fixed  (w_fixed)
  );

  // Sequencer FSM with operand capture and result register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_absa   <= '0;
      r_absb   <= '0;
      r_neg    <= 1'b0;
      r_f3     <= F3_MUL;
      r_result <= '0;
    end else if (Flush) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: if (ReqValid) begin
          r_absa  <= w_absa;
          r_absb  <= w_absb;
          r_neg   <= w_sa ^ w_sb;
          r_f3    <= Funct3;
          r_state <= PP0;
        end
        PP0: r_state <= PP1;
        PP1: r_state <= PP2;
        PP2: r_state <= PP3;
        PP3: r_state <= FIX;
        FIX: begin
          r_result <= (r_f3 == F3_MUL) ? w_fixed[XLEN-1:0] : w_fixed[2*XLEN-1:XLEN];
          r_state  <= DONE;
        end
        DONE: if (RespReady) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl with a behavioural half-width multiplier.
module tb_mul_seq_ctrl;

  localparam int unsigned XLEN = 64;

  logic              clk;
  logic              reset;
  logic              Flush;
  logic              ReqValid;
  logic              ReqReady;
  logic [2:0]        Funct3;
  logic [XLEN-1:0]   SrcA;
  logic [XLEN-1:0]   SrcB;
  logic [XLEN/2-1:0] MulA;
  logic [XLEN/2-1:0] MulB;
  logic [XLEN-1:0]   MulP;
  logic              RespValid;
  logic              RespReady;
  logic [XLEN-1:0]   Result;
  logic              Busy;

  int n_cmp = 0;
  int n_err = 0;

  assign MulP = {32'b0, MulA} * {32'b0, MulB};

  mul_seq_ctrl #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .Flush     (Flush),
    .ReqValid  (ReqValid),
    .ReqReady  (ReqReady),
    .Funct3    (Funct3),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .MulA      (MulA),
    .MulB      (MulB),
    .MulP      (MulP),
    .RespValid (RespValid),
    .RespReady (RespReady),
    .Result    (Result),
    .Busy      (Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request; returns edges from accept to RespValid and the PP0 operands.
  task automatic issue(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                       output int lat, output logic [31:0] pa, output logic [31:0] pb);
    Funct3   = f3;
    SrcA     = a;
    SrcB     = b;
    ReqValid = 1'b1;
    step();
    ReqValid = 1'b0;
    pa  = MulA;
    pb  = MulB;
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      if (i > 1 || lat == 99) begin
        if (RespValid) begin
          lat = i - 1;
          break;
        end
        step();
      end
    end
    if (lat == 99 && RespValid) lat = 20;
  endtask

  int          lat;
  logic [31:0] pa, pb;
  logic        saw_valid;

  initial begin
    reset     = 1'b0;
    Flush     = 1'b0;
    ReqValid  = 1'b0;
    RespReady = 1'b1;
    Funct3    = 3'b000;
    SrcA      = '0;
    SrcB      = '0;
    #12;
    chk("rst_reqready", 64'(ReqReady), 64'd1);
    chk("rst_respvalid", 64'(RespValid), 64'd0);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_result", Result, 64'd0);
    chk("rst_mula", 64'(MulA), 64'd0);
    chk("rst_mulb", 64'(MulB), 64'd0);
    reset = 1'b1;
    step();

    // 1: mul 3*5
    issue(3'b000, 64'd3, 64'd5, lat, pa, pb);
    chk("mul_pp0_mula", 64'(pa), 64'd3);
    chk("mul_pp0_mulb", 64'(pb), 64'd5);
    chk("mul_latency", 64'(lat), 64'd5);
    chk("mul_result", Result, 64'hF);
    step();
    chk("mul_reqready_after", 64'(ReqReady), 64'd1);
    chk("mul_respvalid_after", 64'(RespValid), 64'd0);

    // 2: mulh corner cases
    issue(3'b001, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, lat, pa, pb);
    chk("mulh_minmin_lat", 64'(lat), 64'd5);
    chk("mulh_minmin", Result, 64'h4000_0000_0000_0000);
    step();
    issue(3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, lat, pa, pb);
    chk("mulh_m1m1_pp0_mula", 64'(pa), 64'd1);
    chk("mulh_m1m1", Result, 64'h0);
    step();

    // 3: mulhsu -1 * (2^64-1)
    issue(3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, lat, pa, pb);
    chk("mulhsu_pp0_mulb", 64'(pb), 64'hFFFF_FFFF);
    chk("mulhsu", Result, 64'hFFFF_FFFF_FFFF_FFFF);
    step();

    // 4: mulhu and mul of all-ones
    issue(3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, lat, pa, pb);
    chk("mulhu", Result, 64'hFFFF_FFFF_FFFF_FFFE);
    step();
    issue(3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, lat, pa, pb);
    chk("mul_ones", Result, 64'h1);
    step();

    // 5: back-pressure in DONE, mul 7*9
    RespReady = 1'b0;
    issue(3'b000, 64'd7, 64'd9, lat, pa, pb);
    chk("bp_latency", 64'(lat), 64'd5);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_respvalid", 64'(RespValid), 64'd1);
      chk("bp_result", Result, 64'h3F);
      chk("bp_reqready", 64'(ReqReady), 64'd0);
    end
    RespReady = 1'b1;
    step();
    chk("bp_release_reqready", 64'(ReqReady), 64'd1);
    chk("bp_release_respvalid", 64'(RespValid), 64'd0);

    // Flush in IDLE beats a pending request
    Flush    = 1'b1;
    ReqValid = 1'b1;
    Funct3   = 3'b000;
    SrcA     = 64'd2;
    SrcB     = 64'd2;
    step();
    Flush    = 1'b0;
    ReqValid = 1'b0;
    chk("flush_idle_busy", 64'(Busy), 64'd0);

    // 6: flush during PP2
    Funct3   = 3'b011;
    SrcA     = 64'h0000_0002_0000_0003;
    SrcB     = 64'h0000_0004_0000_0005;
    ReqValid = 1'b1;
    step();
    ReqValid = 1'b0;
    step();
    step();
    chk("pp2_mula", 64'(MulA), 64'd2);
    chk("pp2_mulb", 64'(MulB), 64'd5);
    Flush = 1'b1;
    step();
    Flush = 1'b0;
    chk("flush_busy", 64'(Busy), 64'd0);
    chk("flush_reqready", 64'(ReqReady), 64'd1);
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (RespValid) saw_valid = 1'b1;
      step();
    end
    chk("flush_no_respvalid", 64'(saw_valid), 64'd0);

    // Async reset during PP1 (Result still holds 0x3F beforehand)
    Funct3   = 3'b000;
    SrcA     = 64'h0000_0001_0000_0001;
    SrcB     = 64'h0000_0001_0000_0001;
    ReqValid = 1'b1;
    step();
    ReqValid = 1'b0;
    step();
    chk("pp1_mulb", 64'(MulB), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_reqready", 64'(ReqReady), 64'd1);
    chk("arst_respvalid", 64'(RespValid), 64'd0);
    chk("arst_busy", 64'(Busy), 64'd0);
    chk("arst_result", Result, 64'd0);
    chk("arst_mula", 64'(MulA), 64'd0);
    chk("arst_mulb", 64'(MulB), 64'd0);
    reset = 1'b1;
    step();

    // Operation after reset recovery: mul 6*7
    issue(3'b000, 64'd6, 64'd7, lat, pa, pb);
    chk("post_rst_result", Result, 64'd42);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
